// File: rtl/fetch_bundle_queue_pkg.sv
// Shared types for the frontend-to-rename bundle queue: BTB info and bundle layout.
package fetch_bundle_queue_pkg;

  localparam int unsigned PC_W  = 30;
  localparam int unsigned BTB_W = 37;
  localparam int unsigned INS_W = 96;

  // MSB-first order matches the frontend's fe_btb_i packing.
  typedef struct packed {
    logic [1:0]      btype;
    logic [1:0]      bm_pred;
    logic [PC_W-1:0] target;
    logic            vld;
    logic            idx;
    logic            way;
  } btb_info_t;

  // Decoded instruction payload, opaque to the queue. From MSB to LSB it holds
  // port, types, opcodes, regs, imm, props, hint and exception fields.
  typedef logic [INS_W-1:0] ins_t;

  typedef struct packed {
    ins_t            ins0;
    ins_t            ins1;
    logic            ins1_valid;
    logic [PC_W-1:0] pc;
    btb_info_t       btb;
  } bundle_t;

endpackage

// File: rtl/fetch_bq_ptr.sv
// Wrap-bit read/write pointer pair with full, empty and occupancy for power-of-two queues.
module fetch_bq_ptr #(
  parameter int unsigned C_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(C_DEPTH)-1:0] wr_idx_c,
  output logic [$clog2(C_DEPTH)-1:0] rd_idx_c,
  output logic [$clog2(C_DEPTH):0]   occupancy_c
);

  localparam int unsigned IDX_W = $clog2(C_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Same index with opposite wrap bits means the writer has lapped the reader.
  always_comb begin
    empty_c     = (wr_ptr_q == rd_ptr_q);
    full_c      = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    wr_idx_c    = wr_ptr_q[IDX_W-1:0];
    rd_idx_c    = rd_ptr_q[IDX_W-1:0];
    occupancy_c = PTR_W'(wr_ptr_q - rd_ptr_q);
  end

endmodule

// File: rtl/fetch_bundle_queue.sv
// Decoupling FIFO between decoded frontend bundles and rename; first-word-fall-through head.
module fetch_bundle_queue
  import fetch_bundle_queue_pkg::*;
#(
  parameter int unsigned C_DEPTH  = 8,
  parameter int unsigned C_INS_W  = INS_W,
  parameter int unsigned C_PERF_W = 32
) (
  input  logic                       core_clock_i,
  input  logic                       core_reset_i,
  input  logic                       core_flush_i,
  input  logic                       fe_valid_i,
  input  logic [C_INS_W-1:0]         fe_ins0_i,
  input  logic [C_INS_W-1:0]         fe_ins1_i,
  input  logic                       fe_ins1_valid_i,
  input  logic [PC_W-1:0]            fe_pc_i,
  input  logic [BTB_W-1:0]           fe_btb_i,
  output logic                       fe_busy_o,
  output logic                       rn_valid_o,
  output logic [C_INS_W-1:0]         rn_ins0_o,
  output logic [C_INS_W-1:0]         rn_ins1_o,
  output logic                       rn_ins1_valid_o,
  output logic [PC_W-1:0]            rn_pc_o,
  output logic [BTB_W-1:0]           rn_btb_o,
  input  logic                       rn_busy_i,
  output logic [$clog2(C_DEPTH):0]   occupancy_o,
  output logic [C_PERF_W-1:0]        perf_full_cycles_o
);

  localparam int unsigned IDX_W = $clog2(C_DEPTH);

  // Same layout as bundle_t, but with the instruction width following C_INS_W.
  typedef struct packed {
    logic [C_INS_W-1:0] ins0;
    logic [C_INS_W-1:0] ins1;
    logic               ins1_valid;
    logic [PC_W-1:0]    pc;
    btb_info_t          btb;
  } entry_t;

  entry_t             mem [C_DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [C_PERF_W-1:0] perf_q;

  fetch_bq_ptr #(
    .C_DEPTH (C_DEPTH)
  ) u_ptr (
    .clk         (core_clock_i),
    .rst         (core_reset_i),
    .flush       (core_flush_i),
    .push        (push),
    .pop         (pop),
    .full_c      (full),
    .empty_c     (empty),
    .wr_idx_c    (wr_idx),
    .rd_idx_c    (rd_idx),
    .occupancy_c (occupancy_o)
  );

  // A full queue refuses the push even if it pops this cycle.
  always_comb begin
    push = fe_valid_i && !full && !core_flush_i;
    pop  = !empty && !rn_busy_i && !core_flush_i;

    wr_entry            = '0;
    wr_entry.ins0       = fe_ins0_i;
    wr_entry.ins1       = fe_ins1_i;
    wr_entry.ins1_valid = fe_ins1_valid_i;
    wr_entry.pc         = fe_pc_i;
    wr_entry.btb        = btb_info_t'(fe_btb_i);
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge core_clock_i) begin
    if (push) mem[wr_idx] <= wr_entry;
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      perf_q <= '0;
    end else if (full && (perf_q != '1)) begin
      perf_q <= perf_q + C_PERF_W'(1);
    end
  end

  always_comb begin
    head               = mem[rd_idx];
    fe_busy_o          = full;
    rn_valid_o         = !empty;
    rn_ins0_o          = head.ins0;
    rn_ins1_o          = head.ins1;
    rn_ins1_valid_o    = head.ins1_valid;
    rn_pc_o            = head.pc;
    rn_btb_o           = BTB_W'(head.btb);
    perf_full_cycles_o = perf_q;
  end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed self-checking bench for fetch_bundle_queue (depth 8, 4-bit perf counter).
module tb_fetch_bundle_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned INS_W  = 96;
  localparam int unsigned PERF_W = 4;

  logic              clk;
  logic              core_reset;
  logic              core_flush;
  logic              fe_valid;
  logic [INS_W-1:0]  fe_ins0;
  logic [INS_W-1:0]  fe_ins1;
  logic              fe_ins1_valid;
  logic [29:0]       fe_pc;
  logic [36:0]       fe_btb;
  logic              fe_busy;
  logic              rn_valid;
  logic [INS_W-1:0]  rn_ins0;
  logic [INS_W-1:0]  rn_ins1;
  logic              rn_ins1_valid;
  logic [29:0]       rn_pc;
  logic [36:0]       rn_btb;
  logic              rn_busy;
  logic [3:0]        occupancy;
  logic [PERF_W-1:0] perf;

  int checks;
  int errors;

  fetch_bundle_queue #(
    .C_DEPTH  (DEPTH),
    .C_INS_W  (INS_W),
    .C_PERF_W (PERF_W)
  ) dut (
    .core_clock_i       (clk),
    .core_reset_i       (core_reset),
    .core_flush_i       (core_flush),
    .fe_valid_i         (fe_valid),
    .fe_ins0_i          (fe_ins0),
    .fe_ins1_i          (fe_ins1),
    .fe_ins1_valid_i    (fe_ins1_valid),
    .fe_pc_i            (fe_pc),
    .fe_btb_i           (fe_btb),
    .fe_busy_o          (fe_busy),
    .rn_valid_o         (rn_valid),
    .rn_ins0_o          (rn_ins0),
    .rn_ins1_o          (rn_ins1),
    .rn_ins1_valid_o    (rn_ins1_valid),
    .rn_pc_o            (rn_pc),
    .rn_btb_o           (rn_btb),
    .rn_busy_i          (rn_busy),
    .occupancy_o        (occupancy),
    .perf_full_cycles_o (perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [INS_W-1:0] mk_ins(input logic [29:0] pc, input logic sel);
    return {(sel ? 32'hBBBB_0001 : 32'hAAAA_0000), 34'h0, pc};
  endfunction

  function automatic logic [36:0] mk_btb(input logic [29:0] pc);
    return {pc[1:0], pc[3:2], pc + 30'd5, pc[0], pc[1], pc[2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [29:0] pc);
    fe_valid      = v;
    fe_pc         = pc;
    fe_ins0       = mk_ins(pc, 1'b0);
    fe_ins1       = mk_ins(pc, 1'b1);
    fe_ins1_valid = pc[0];
    fe_btb        = mk_btb(pc);
  endtask

  task automatic check_head(input string tag, input logic [29:0] pc);
    check({tag, "_valid"}, 128'(rn_valid), 128'(1'b1));
    check({tag, "_pc"}, 128'(rn_pc), 128'(pc));
    check({tag, "_ins0"}, 128'(rn_ins0), 128'(mk_ins(pc, 1'b0)));
    check({tag, "_ins1"}, 128'(rn_ins1), 128'(mk_ins(pc, 1'b1)));
    check({tag, "_ins1v"}, 128'(rn_ins1_valid), 128'(pc[0]));
    check({tag, "_btb"}, 128'(rn_btb), 128'(mk_btb(pc)));
  endtask

  task automatic do_reset();
    core_reset = 1'b1;
    core_flush = 1'b0;
    rn_busy    = 1'b0;
    set_in(1'b0, 30'h0);
    tick();
    tick();
    core_reset = 1'b0;
  endtask

  // Pushes n bundles starting at base while rename is stalled.
  task automatic fill(input int n, input logic [29:0] base);
    rn_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, base + 30'(i));
      tick();
    end
    set_in(1'b0, 30'h0);
  endtask

  logic [31:0] busy_pat;
  int          p;
  int          c;

  initial begin
    checks   = 0;
    errors   = 0;
    busy_pat = 32'b1011_0011_1000_1111_0010_0110_1101_0001;

    // Reset state
    do_reset();
    check("rst_valid", 128'(rn_valid), 128'(1'b0));
    check("rst_busy", 128'(fe_busy), 128'(1'b0));
    check("rst_occ", 128'(occupancy), 128'(4'd0));
    check("rst_perf", 128'(perf), 128'(4'd0));

    // Three bundles flowing straight through
    set_in(1'b1, 30'h100);
    check("s1_pre_valid", 128'(rn_valid), 128'(1'b0));
    tick();
    check_head("s1_a", 30'h100);
    set_in(1'b1, 30'h101);
    tick();
    check_head("s1_b", 30'h101);
    set_in(1'b1, 30'h102);
    tick();
    check_head("s1_c", 30'h102);
    set_in(1'b0, 30'h0);
    tick();
    check("s1_drained", 128'(rn_valid), 128'(1'b0));

    // Fill to full under back-pressure; 9th bundle held off
    do_reset();
    rn_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 30'h200 + 30'(i));
      tick();
      check("s2_occ", 128'(occupancy), 128'(i + 1));
    end
    check("s2_full", 128'(fe_busy), 128'(1'b1));
    check("s2_perf0", 128'(perf), 128'(4'd0));
    set_in(1'b1, 30'h2FF);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("s2_perf", 128'(perf), 128'(i));
      check("s2_occ_held", 128'(occupancy), 128'(4'd8));
    end
    check_head("s2_head", 30'h200);

    // Release: first cycle pops only, then push+pop together
    rn_busy = 1'b0;
    tick();
    check("s3_occ_a", 128'(occupancy), 128'(4'd7));
    check("s3_busy_a", 128'(fe_busy), 128'(1'b0));
    check("s3_perf", 128'(perf), 128'(4'd4));
    check_head("s3_h1", 30'h201);
    tick();
    set_in(1'b0, 30'h0);
    check("s3_occ_b", 128'(occupancy), 128'(4'd7));
    check_head("s3_h2", 30'h202);
    for (int i = 3; i <= 7; i++) begin
      tick();
      check_head("s3_drain", 30'h200 + 30'(i));
    end
    tick();
    check_head("s3_held", 30'h2FF);
    tick();
    check("s3_empty", 128'(rn_valid), 128'(1'b0));

    // Stream 20 bundles across the pointer wrap with stalls
    do_reset();
    p = 0;
    c = 0;
    for (int cyc = 0; cyc < 200 && c < 20; cyc++) begin
      rn_busy = busy_pat[cyc % 32];
      set_in(p < 20, 30'(32'h300 + p));
      if (rn_valid) check_head("s4", 30'(32'h300 + c));
      if (rn_valid && !rn_busy) c++;
      if (p < 20 && !fe_busy) p++;
      tick();
    end
    set_in(1'b0, 30'h0);
    rn_busy = 1'b0;
    check("s4_count", 128'(c), 128'(20));
    check("s4_empty", 128'(rn_valid), 128'(1'b0));

    // Flush at occupancy 5 beats push and pop
    do_reset();
    fill(5, 30'h400);
    check("s5_occ", 128'(occupancy), 128'(4'd5));
    core_flush = 1'b1;
    rn_busy    = 1'b0;
    set_in(1'b1, 30'h4FF);
    tick();
    core_flush = 1'b0;
    set_in(1'b0, 30'h0);
    check("s5_occ0", 128'(occupancy), 128'(4'd0));
    check("s5_valid", 128'(rn_valid), 128'(1'b0));
    check("s5_busy", 128'(fe_busy), 128'(1'b0));
    tick();
    check("s5_still_empty", 128'(rn_valid), 128'(1'b0));
    rn_busy = 1'b1;
    set_in(1'b1, 30'h4AA);
    tick();
    set_in(1'b0, 30'h0);
    check_head("s5_fresh", 30'h4AA);

    // Flush does not clear the perf counter
    do_reset();
    fill(8, 30'h500);
    tick();
    tick();
    check("s5_perf_pre", 128'(perf), 128'(4'd2));
    core_flush = 1'b1;
    tick();
    core_flush = 1'b0;
    tick();
    check("s5_perf_kept", 128'(perf), 128'(4'd3));
    check("s5_occ_after", 128'(occupancy), 128'(4'd0));

    // Perf counter saturation and reset
    do_reset();
    fill(8, 30'h600);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("s6_perf14", 128'(perf), 128'(4'd14));
      if (i == 15) check("s6_perf15", 128'(perf), 128'(4'd15));
    end
    check("s6_sat", 128'(perf), 128'(4'd15));
    core_reset = 1'b1;
    set_in(1'b1, 30'h6FF);
    tick();
    check("s6_rst_perf", 128'(perf), 128'(4'd0));
    check("s6_rst_occ", 128'(occupancy), 128'(4'd0));
    core_reset = 1'b0;
    set_in(1'b0, 30'h0);
    tick();
    check("s6_rst_push_dropped", 128'(rn_valid), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
- Decoupling FIFO between the frontend's decoded two-instruction bundle output and the rename stage.
- Absorbs rename back-pressure, so the frontend sees a simple busy signal rather than rename's stall timing.
- Presents the oldest bundle to rename in first-word-fall-through fashion.
- Discards all contents on a core flush.

Parameters:
C_DEPTH, 8, number of bundle entries; power of two, minimum 2
C_INS_W, 96, width of one packed decoded-instruction payload (port, types, opcodes, regs, imm, props, hint, exception fields)
C_PERF_W, 32, width of the saturating full-cycle counter

Ports:
core_clock_i  in  1  sole clock; all state updates on the rising edge
core_reset_i  in  1  synchronous, active-high reset
core_flush_i  in  1  pipeline flush; discard all entries
fe_valid_i  in  1  frontend bundle valid
fe_ins0_i  in  C_INS_W  packed instruction 0
fe_ins1_i  in  C_INS_W  packed instruction 1
fe_ins1_valid_i  in  1  instruction 1 present
fe_pc_i  in  30  bundle word PC
fe_btb_i  in  37  packed {btype[2], bm_pred[2], target[30], vld, idx, way}
fe_busy_o  out  1  queue full; drives the frontend's rn_busy_i
rn_valid_o  out  1  head entry valid
rn_ins0_o  out  C_INS_W  head instruction 0
rn_ins1_o  out  C_INS_W  head instruction 1
rn_ins1_valid_o  out  1  head instruction 1 present
rn_pc_o  out  30  head PC
rn_btb_o  out  37  head BTB info
rn_busy_i  in  1  rename cannot accept this cycle
occupancy_o  out  $clog2(C_DEPTH)+1  current entry count
perf_full_cycles_o  out  C_PERF_W  cycles spent full, saturating

Behaviour:
- Storage and pointers
  - Storage is C_DEPTH entries plus read and write pointers, each $clog2(C_DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = pointers equal. full = index bits equal and wrap bits differ.
- Handshakes
  - push = fe_valid_i & !full & !core_flush_i.
  - pop = !empty & !rn_busy_i & !core_flush_i.
- Outputs
  - fe_busy_o = full, combinational from the registered pointers only.
  - A full queue popping in the same cycle still rejects the push. The frontend must hold its bundle while fe_busy_o is high.
  - rn_valid_o = !empty. The rn_* data outputs read the entry at the read pointer combinationally, so latency is 0 cycles for data already stored.
  - An empty queue being pushed has 1-cycle latency: the bundle appears on rn_* the next cycle. There is no bypass.
- Simultaneous push and pop when neither full nor empty: both pointers advance and occupancy is unchanged.
- Wrap-around: index bits roll from C_DEPTH-1 to 0 and the wrap bit toggles. No entry is lost or duplicated.
- occupancy_o = write pointer − read pointer, modulo 2^(ptr width).
- Flush
  - core_flush_i has priority over push and pop; the pointers reset to 0 next cycle.
  - The cycle after flush: rn_valid_o=0, fe_busy_o=0, occupancy_o=0.
  - Entry RAM contents are not cleared.
  - perf_full_cycles_o is not cleared by flush.
- Reset: pointers=0, perf counter=0, so rn_valid_o=0, fe_busy_o=0, occupancy_o=0. Reset during a push discards that push.
- Perf counter: increments each cycle that full is high, saturates at all-ones, and is cleared only by reset.
- While rn_valid_o is high and rn_busy_i is high, the rn_* outputs must be stable.

Decomposition:
- Shared package: the bundle entry struct {ins0, ins1, ins1_valid, pc, btb}, the BTB-info struct with fields btype, bm_pred, target, vld, idx, way, and the C_INS_W packing order used by the frontend and rename.
- One sub-module, fetch_bq_ptr, holds the pointer pair, full/empty logic and occupancy computation, reusable by other queues.
- Entry storage is inferred distributed RAM in the top module.

Test Plan:
- Reset, then push 3 bundles with PC 0x100, 0x101, 0x102 and rn_busy_i=0 -> rn_valid_o rises one cycle after the first push; PCs emerge in order, one per cycle.
- rn_busy_i=1, push 8 bundles -> occupancy_o=8, fe_busy_o=1. A 9th fe_valid_i is held and not stored. perf_full_cycles_o increments each full cycle.
- Full queue, rn_busy_i=0 with fe_valid_i=1 -> first cycle pops only (occupancy 7). Next cycle push and pop together, occupancy stays 7, and the held bundle is the 8th popped after it.
- Stream 20 bundles through with a random rn_busy_i pattern -> all 20 received in order with matching ins1_valid and BTB fields across the pointer wrap.
- Occupancy 5, assert core_flush_i with fe_valid_i=1 and rn_busy_i=0 -> next cycle occupancy_o=0 and rn_valid_o=0; neither the push nor the pop takes effect.
- Force the perf counter near all-ones (C_PERF_W=4 build), hold full for 20 cycles -> saturates at 15; core_reset_i returns it to 0.
